// File: rtl/sc_arb_pkg.sv
// rtl/sc_arb_pkg.sv - shared state encoding and counter widths for sc_mem_arbiter
package sc_arb_pkg;

    typedef enum logic {
        ARB_CPU_OWN = 1'b0,
        ARB_DMA_OWN = 1'b1
    } arb_state_e;

    localparam int WAIT_W  = 8;
    localparam int BURST_W = 4;
    localparam int STAT_W  = 16;

endpackage

// File: rtl/sc_arb_sat_cnt.sv
// rtl/sc_arb_sat_cnt.sv - saturating up-counter with synchronous clear (clear wins over increment)
module sc_arb_sat_cnt #(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != W'(MAX))) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/sc_mem_arbiter.sv
// rtl/sc_mem_arbiter.sv - CPU/DMA data-memory arbiter with starvation guard and bounded DMA bursts
// Optional statistics outputs enabled by defining SC_ARB_STATS_EN.
module sc_mem_arbiter
    import sc_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_BURST    = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [31:0]       dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_gnt,
    output logic [31:0]       dma_rdata,
    output logic              dma_rvalid,
`ifdef SC_ARB_STATS_EN
    output logic [STAT_W-1:0] stat_stall_cnt,
    output logic [STAT_W-1:0] stat_dma_beats,
`endif
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    arb_state_e         state, state_nxt;
    logic [BURST_W-1:0] burst_cnt, burst_nxt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               starve;
    logic               wait_inc, wait_clr;

    assign starve = (wait_cnt == WAIT_W'(STARVE_LIMIT));

    // Grant/stall are gated by resetn so they read as idle for the whole reset pulse.
    always_comb begin
        dma_gnt   = 1'b0;
        cpu_stall = 1'b0;
        state_nxt = state;
        burst_nxt = burst_cnt;
        if (resetn) begin
            case (state)
                ARB_CPU_OWN: begin
                    dma_gnt = dma_req && (!cpu_req || starve);
                    if (dma_gnt && cpu_req) begin
                        cpu_stall = 1'b1;
                        if (MAX_BURST > 1) begin
                            state_nxt = ARB_DMA_OWN;
                            burst_nxt = BURST_W'(1);
                        end
                    end
                end
                ARB_DMA_OWN: begin
                    dma_gnt   = dma_req;
                    cpu_stall = cpu_req;
                    if (!dma_req || (burst_cnt + BURST_W'(1) == BURST_W'(MAX_BURST))) begin
                        state_nxt = ARB_CPU_OWN;
                        burst_nxt = '0;
                    end else begin
                        burst_nxt = burst_cnt + BURST_W'(1);
                    end
                end
                default: begin
                    state_nxt = ARB_CPU_OWN;
                    burst_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = resetn && cpu_we && cpu_req && !cpu_stall;
        if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = resetn && dma_we;
        end
    end

    assign cpu_rdata = mem_rdata;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ARB_CPU_OWN;
            burst_cnt  <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            state      <= state_nxt;
            burst_cnt  <= burst_nxt;
            dma_rvalid <= dma_gnt && !dma_we;
            if (dma_gnt && !dma_we) begin
                dma_rdata <= mem_rdata;
            end
        end
    end

    assign wait_inc = (state == ARB_CPU_OWN) && dma_req && !dma_gnt;
    assign wait_clr = (state == ARB_DMA_OWN) || dma_gnt || !dma_req;

    sc_arb_sat_cnt #(.W(WAIT_W), .MAX(STARVE_LIMIT)) u_wait_cnt (
        .clock  (clock),
        .resetn (resetn),
        .inc    (wait_inc),
        .clr    (wait_clr),
        .count  (wait_cnt)
    );

`ifdef SC_ARB_STATS_EN
    sc_arb_sat_cnt #(.W(STAT_W), .MAX((1 << STAT_W) - 1)) u_stat_stall (
        .clock  (clock),
        .resetn (resetn),
        .inc    (cpu_stall),
        .clr    (1'b0),
        .count  (stat_stall_cnt)
    );

    sc_arb_sat_cnt #(.W(STAT_W), .MAX((1 << STAT_W) - 1)) u_stat_beats (
        .clock  (clock),
        .resetn (resetn),
        .inc    (dma_gnt),
        .clr    (1'b0),
        .count  (stat_dma_beats)
    );
`endif

endmodule

// File: tb/tb_sc_mem_arbiter.sv
// tb/tb_sc_mem_arbiter.sv - self-checking bench for sc_mem_arbiter (optionally with SC_ARB_STATS_EN)
module tb_sc_mem_arbiter;

    localparam int SL = 8;
    localparam int MB = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
`ifdef SC_ARB_STATS_EN
    logic [15:0] stat_stall_cnt, stat_dma_beats;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sc_mem_arbiter #(.STARVE_LIMIT(SL), .MAX_BURST(MB)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
`ifdef SC_ARB_STATS_EN
        .stat_stall_cnt (stat_stall_cnt),
        .stat_dma_beats (stat_dma_beats),
`endif
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    // Data memory: unwritten words read as 0xA50000nn (nn = word index).
    logic [31:0] mem [0:255];
    bit          written [0:255] = '{default: 1'b0};
    logic [7:0]  rd_idx;

    always_comb begin
        rd_idx    = mem_addr[9:2];
        mem_rdata = written[rd_idx] ? mem[rd_idx] : (32'hA500_0000 | 32'(rd_idx));
    end

    always @(posedge clock) begin
        if (mem_we) begin
            mem[mem_addr[9:2]]     <= mem_wdata;
            written[mem_addr[9:2]] <= 1'b1;
        end
    end

    function automatic logic [31:0] peek(input logic [31:0] addr);
        logic [7:0] i;
        i = addr[9:2];
        return written[i] ? mem[i] : (32'hA500_0000 | 32'(i));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: ownership flag, cycles waited, beats taken, read-return pipeline.
    bit          m_dma_owns;
    int          m_waited, m_beats, m_stalls, m_grants;
    bit          m_rv;
    logic [31:0] m_rd;
    logic        e_gnt, e_stall, e_we;
    logic [31:0] e_addr, e_wdata;

    always_comb begin
        e_gnt   = 1'b0;
        e_stall = 1'b0;
        if (resetn) begin
            if (m_dma_owns) begin
                e_gnt   = dma_req;
                e_stall = cpu_req;
            end else begin
                e_gnt   = dma_req && (!cpu_req || (m_waited >= SL));
                e_stall = e_gnt && cpu_req;
            end
        end
        e_addr  = e_gnt ? dma_addr : cpu_addr;
        e_wdata = e_gnt ? dma_wdata : cpu_wdata;
        e_we    = resetn && (e_gnt ? dma_we : (cpu_we && cpu_req && !e_stall));
    end

    always @(posedge clock or negedge resetn) begin
        bit g, s;
        if (!resetn) begin
            m_dma_owns = 0; m_waited = 0; m_beats = 0;
            m_rv = 0; m_rd = '0; m_stalls = 0; m_grants = 0;
        end else begin
            g = e_gnt;
            s = e_stall;
            if (s) m_stalls++;
            if (g) m_grants++;
            m_rv = g && !dma_we;
            if (m_rv) m_rd = peek(dma_addr);
            if (m_dma_owns) begin
                m_waited = 0;
                if (g) m_beats++;
                if (!dma_req || m_beats >= MB) begin
                    m_dma_owns = 0;
                    m_beats    = 0;
                end
            end else if (g && cpu_req) begin
                m_waited = 0;
                if (MB > 1) begin
                    m_dma_owns = 1;
                    m_beats    = 1;
                end
            end else if (g || !dma_req) begin
                m_waited = 0;
            end else if (m_waited < SL) begin
                m_waited++;
            end
        end
    end

    always @(negedge clock) begin
        if (resetn) begin
            chk("dma_gnt", 32'(dma_gnt), 32'(e_gnt));
            chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("cpu_rdata", cpu_rdata, peek(e_addr));
            chk("dma_rvalid", 32'(dma_rvalid), 32'(m_rv));
            chk("dma_rdata", dma_rdata, m_rd);
`ifdef SC_ARB_STATS_EN
            chk("stat_stall_cnt", 32'(stat_stall_cnt), 32'(m_stalls));
            chk("stat_dma_beats", 32'(stat_dma_beats), 32'(m_grants));
`endif
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        cpu_req = 0; cpu_we = 0; dma_we = 0; dma_req = 1;
        resetn = 0;
        #1;
        chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        chk("rst_dma_rdata", dma_rdata, 32'd0);
        step();
        resetn  = 1;
        dma_req = 0;
        step();
    endtask

    task automatic wait_grant(output int n);
        n = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (dma_gnt) begin
                n = k;
                break;
            end
            step();
        end
    endtask

    initial begin
        int gcount, n;
        step();

        // Opportunistic DMA reads, CPU idle.
        do_reset();
        gcount = 0;
        for (int i = 0; i < 6; i++) begin
            dma_req = 1; dma_we = 0; dma_addr = 32'h10 + 32'(4 * i);
            @(negedge clock);
            if (dma_gnt) gcount++;
            if (i > 0) begin
                chk("s1_rvalid", 32'(dma_rvalid), 32'd1);
                chk("s1_rdata", dma_rdata, 32'hA500_0004 + 32'(i - 1));
            end
            step();
        end
        dma_req = 0;
        @(negedge clock);
        chk("s1_grants", 32'(gcount), 32'd6);
        chk("s1_last_rdata", dma_rdata, 32'hA500_0009);
        step();
        cpu_req = 1; dma_req = 1;
        @(negedge clock);
        chk("s1_still_cpu_own", 32'(cpu_stall), 32'd0);
        step();

        // Continuous contention: 8 waits then 4 forced beats, three rounds.
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h80;
        dma_req = 1; dma_we = 0; dma_addr = 32'h30;
        gcount = 0;
        for (int c = 0; c < 36; c++) begin
            @(negedge clock);
            chk("s2_gnt_pattern", 32'(dma_gnt), 32'((c % 12) >= 8));
            chk("s2_stall_pattern", 32'(cpu_stall), 32'((c % 12) >= 8));
            if (dma_gnt) gcount++;
            step();
        end
        chk("s2_grants", 32'(gcount), 32'd12);
`ifdef SC_ARB_STATS_EN
        chk("s2_stat_stall", 32'(stat_stall_cnt), 32'd12);
        chk("s2_stat_beats", 32'(stat_dma_beats), 32'd12);
`endif
        dma_req = 0;
        step();

        // DMA write during forced takeover; stalled CPU store must not land.
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'h1111_1111;
        dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'hDEAD_BEEF;
        wait_grant(n);
        chk("s3_grant_cycle", 32'(n), 32'd8);
        chk("s3_stall_on_grant", 32'(cpu_stall), 32'd1);
        chk("s3_dma_wdata", mem_wdata, 32'hDEAD_BEEF);
        step();
        dma_req = 0;
        @(negedge clock);
        chk("s3_stall_after", 32'(cpu_stall), 32'd1);
        chk("s3_no_cpu_store", 32'(mem_we), 32'd0);
        step();
        cpu_we = 0;
        @(negedge clock);
        chk("s3_unstalled", 32'(cpu_stall), 32'd0);
        chk("s3_cpu_load", cpu_rdata, 32'hDEAD_BEEF);
        step();
        cpu_req = 0;

        // dma_req drops after two beats.
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h80;
        dma_req = 1; dma_we = 0; dma_addr = 32'h50;
        wait_grant(n);
        chk("s4_beat1", 32'(n), 32'd8);
        step();
        @(negedge clock);
        chk("s4_beat2_gnt", 32'(dma_gnt), 32'd1);
        step();
        dma_req = 0;
        @(negedge clock);
        chk("s4_drop_stall", 32'(cpu_stall), 32'd1);
        step();
        @(negedge clock);
        chk("s4_released", 32'(cpu_stall), 32'd0);
        step();

        // Reset asserted during beat 2 of a burst.
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h84; cpu_wdata = 32'h2222_2222;
        dma_req = 1; dma_we = 0; dma_addr = 32'h54;
        wait_grant(n);
        step();
        @(negedge clock);
        chk("s5_beat2_rvalid", 32'(dma_rvalid), 32'd1);
        chk("s5_beat2_stall", 32'(cpu_stall), 32'd1);
        #2;
        resetn = 0;
        #1;
        chk("s5_rst_stall", 32'(cpu_stall), 32'd0);
        chk("s5_rst_mem_we", 32'(mem_we), 32'd0);
        chk("s5_rst_rvalid", 32'(dma_rvalid), 32'd0);
        chk("s5_rst_gnt", 32'(dma_gnt), 32'd0);
        step();
        resetn = 1; cpu_we = 0;
        @(negedge clock);
        chk("s5_cpu_own_gnt", 32'(dma_gnt), 32'd0);
        chk("s5_cpu_own_stall", 32'(cpu_stall), 32'd0);
        step();
        cpu_req = 0; dma_req = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
